// File: rtl/branch_unit.sv
// Resolves conditional branches through LAT register stages and trains a 2-bit counter BHT on each retire.
// Output stalls when outReady is low; inReady drops only when the first stage is full and cannot advance.
module branch_unit #(
  parameter int XLEN      = 32,
  parameter int LAT       = 2,
  parameter int BHT_DEPTH = 64
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            inValid,
  output logic            inReady,
  input  logic [2:0]      bCtrl,
  input  logic [XLEN-1:0] r1,
  input  logic [XLEN-1:0] r2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            predTaken,
  input  logic            flush,
  output logic            outValid,
  input  logic            outReady,
  output logic            bSel,
  output logic [XLEN-1:0] target,
  output logic            mispredict,
  output logic            illegal,
  input  logic [XLEN-1:0] lookupPc,
  output logic            lookupTaken
);

  localparam int IDXW = $clog2(BHT_DEPTH);

  typedef struct packed {
    logic            bsel;
    logic            illegal;
    logic            mispredict;
    logic [XLEN-1:0] target;
    logic [IDXW-1:0] idx;
  } res_t;

  res_t            new_res;
  res_t            stg [LAT];
  logic [LAT-1:0]  vld;
  logic [LAT:0]    stage_free;
  logic [LAT:0]    load;
  logic            taken;
  logic            bad;
  logic [1:0]      bht [BHT_DEPTH];
  res_t            out_res;

  always_comb begin
    taken = 1'b0;
    bad   = 1'b0;
    case (bCtrl)
      3'b000:  taken = (r1 == r2);
      3'b001:  taken = (r1 != r2);
      3'b100:  taken = ($signed(r1) <  $signed(r2));
      3'b101:  taken = ($signed(r1) >= $signed(r2));
      3'b110:  taken = (r1 <  r2);
      3'b111:  taken = (r1 >= r2);
      default: bad   = 1'b1;
    endcase
    new_res.bsel       = taken;
    new_res.illegal    = bad;
    new_res.mispredict = taken ^ predTaken;
    new_res.target     = taken ? (pc + imm) : (pc + XLEN'(4));
    new_res.idx        = pc[IDXW+1:2];
  end

  // load[i+1] means stage i hands its entry onward; load[LAT] is the output handshake.
  always_comb begin
    stage_free[LAT] = outReady;
    load            = '0;
    for (int i = LAT - 1; i >= 0; i--) begin
      load[i+1]     = vld[i] & stage_free[i+1];
      stage_free[i] = ~vld[i] | load[i+1];
    end
    load[0] = inValid & stage_free[0] & ~flush;
  end

  assign inReady = stage_free[0];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      vld <= '0;
      for (int i = 0; i < LAT; i++) stg[i] <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      for (int i = 0; i < LAT; i++) begin
        if (stage_free[i]) vld[i] <= load[i];
      end
      for (int i = 1; i < LAT; i++) begin
        if (load[i]) stg[i] <= stg[i-1];
      end
      if (load[0]) stg[0] <= new_res;
    end
  end

  assign out_res    = stg[LAT-1];
  assign outValid   = vld[LAT-1];
  assign bSel       = out_res.bsel;
  assign target     = out_res.target;
  assign mispredict = out_res.mispredict;
  assign illegal    = out_res.illegal;

  // Training follows the output handshake, which still completes in a flush cycle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
    end else if (load[LAT] && !out_res.illegal) begin
      if (out_res.bsel) begin
        if (bht[out_res.idx] != 2'b11) bht[out_res.idx] <= bht[out_res.idx] + 2'd1;
      end else begin
        if (bht[out_res.idx] != 2'b00) bht[out_res.idx] <= bht[out_res.idx] - 2'd1;
      end
    end
  end

  assign lookupTaken = bht[lookupPc[IDXW+1:2]][1];

  logic unused_lookup_bits;
  assign unused_lookup_bits = ^{lookupPc[XLEN-1:IDXW+2], lookupPc[1:0]};

endmodule

// File: tb/tb_branch_unit.sv
// Directed-vector bench for branch_unit (XLEN=32, LAT=2, BHT_DEPTH=64).
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid, inReady, predTaken, flush;
  logic [2:0]  bCtrl;
  logic [31:0] r1, r2, pc, imm, target, lookupPc;
  logic        outValid, outReady, bSel, mispredict, illegal, lookupTaken;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  branch_unit #(.XLEN(32), .LAT(2), .BHT_DEPTH(64)) dut (
    .clk(clk), .rstN(rstN), .inValid(inValid), .inReady(inReady), .bCtrl(bCtrl),
    .r1(r1), .r2(r2), .pc(pc), .imm(imm), .predTaken(predTaken), .flush(flush),
    .outValid(outValid), .outReady(outReady), .bSel(bSel), .target(target),
    .mispredict(mispredict), .illegal(illegal), .lookupPc(lookupPc),
    .lookupTaken(lookupTaken)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request with outReady high: accepted at the next edge, result visible two edges later.
  task automatic run_one(input string tag, input logic [2:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] p, input logic [31:0] i,
                         input logic pt, input logic e_bsel, input logic [31:0] e_tgt,
                         input logic e_mis, input logic e_ill);
    @(negedge clk);
    bCtrl = ctl; r1 = a; r2 = b; pc = p; imm = i; predTaken = pt; inValid = 1'b1;
    #1 chk({tag, "_rdy"}, inReady, 1);
    @(negedge clk);
    inValid = 1'b0;
    #1 chk({tag, "_lat"}, outValid, 0);
    @(negedge clk);
    #1;
    chk({tag, "_vld"}, outValid, 1);
    chk({tag, "_bsel"}, bSel, e_bsel);
    chk({tag, "_tgt"}, target, e_tgt);
    chk({tag, "_mis"}, mispredict, e_mis);
    chk({tag, "_ill"}, illegal, e_ill);
  endtask

  int          bk_kind [10] = '{0, 0, 0, 1, 2, 1, 1, 1, 0, 0};
  logic        bk_post [10] = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
  logic [31:0] st_tgt  [6]  = '{32'h1080, 32'h1014, 32'h10A0, 32'h1034, 32'h10C0, 32'h1054};
  logic        st_bsel [6]  = '{1, 0, 1, 0, 1, 0};

  initial begin
    logic        prev;
    int          sent, got;
    logic        held_v;
    logic [33:0] held;

    rstN = 1'b0; inValid = 1'b0; bCtrl = 3'b000; r1 = '0; r2 = '0; pc = '0; imm = '0;
    predTaken = 1'b0; flush = 1'b0; outReady = 1'b1; lookupPc = 32'h40;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ov", outValid, 0);
    chk("rst_bsel", bSel, 0);
    chk("rst_tgt", target, 0);
    chk("rst_mis", mispredict, 0);
    chk("rst_ill", illegal, 0);
    chk("rst_bht", lookupTaken, 0);
    @(negedge clk);
    rstN = 1'b1;
    #1 chk("rst_rdy", inReady, 1);

    run_one("beq_eq",  3'b000, 32'hF0000000, 32'hF0000000, 32'h100, 32'h20, 0, 1, 32'h120, 1, 0);
    run_one("blt",     3'b100, 32'hF0000000, 32'h1, 32'h200, 32'h40, 1, 1, 32'h240, 0, 0);
    run_one("bltu",    3'b110, 32'hF0000000, 32'h1, 32'h200, 32'h40, 1, 0, 32'h204, 1, 0);
    run_one("bgeu",    3'b111, 32'hF0000000, 32'h1, 32'h200, 32'h40, 0, 1, 32'h240, 1, 0);
    run_one("bge",     3'b101, 32'hF0000000, 32'h1, 32'h200, 32'h40, 0, 0, 32'h204, 0, 0);
    run_one("bne",     3'b001, 32'h5, 32'h5, 32'h300, 32'h10, 1, 0, 32'h304, 1, 0);
    run_one("ill010",  3'b010, 32'hF0000000, 32'h1, 32'h200, 32'h40, 1, 0, 32'h204, 1, 1);
    run_one("ill011",  3'b011, 32'h0, 32'h0, 32'h200, 32'h40, 0, 0, 32'h204, 0, 1);
    run_one("wrap_t",  3'b000, 32'h7, 32'h7, 32'hFFFFFFFC, 32'h8, 1, 1, 32'h4, 0, 0);
    run_one("wrap_nt", 3'b001, 32'h7, 32'h7, 32'hFFFFFFFC, 32'h8, 0, 0, 32'h0, 0, 0);

    // Counter walk at pc 0x40: T T T N I N N N T T
    prev = 1'b0;
    for (int k = 0; k < 10; k++) begin
      case (bk_kind[k])
        0:       run_one("bht_t", 3'b000, 32'h1, 32'h1, 32'h40, 32'h10, 0, 1, 32'h50, 1, 0);
        1:       run_one("bht_n", 3'b000, 32'h1, 32'h2, 32'h40, 32'h10, 0, 0, 32'h44, 0, 0);
        default: run_one("bht_i", 3'b010, 32'h1, 32'h1, 32'h40, 32'h10, 0, 0, 32'h44, 0, 1);
      endcase
      chk("bht_pre", lookupTaken, prev);
      @(negedge clk);
      #1 chk("bht_post", lookupTaken, bk_post[k]);
      prev = bk_post[k];
    end

    // Flush with two not-taken requests in flight at pc 0x40 (counter is 10).
    @(negedge clk);
    outReady = 1'b0; bCtrl = 3'b000; r1 = 32'h1; r2 = 32'h2; pc = 32'h40; imm = 32'h10;
    predTaken = 1'b0; inValid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("fl_pre", outValid, 1);
    flush = 1'b1; r2 = 32'h1;
    @(negedge clk);
    flush = 1'b0; inValid = 1'b0;
    #1 chk("fl_ov", outValid, 0);
    outReady = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("fl_drop", outValid, 0);
    end
    chk("fl_bht", lookupTaken, 1);
    run_one("fl_next", 3'b001, 32'h1, 32'h2, 32'h100, 32'h20, 1, 1, 32'h120, 0, 0);

    // Six back-to-back requests with outReady low for cycles 3..5.
    sent = 0; got = 0; held_v = 1'b0; held = '0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      outReady = !(c >= 3 && c <= 5);
      inValid  = (sent < 6);
      if (sent < 6) begin
        bCtrl = 3'b000; pc = 32'h1000 + 32'h10 * sent; imm = 32'h80; predTaken = 1'b0;
        r1 = sent; r2 = (sent % 2 == 0) ? sent : 0;
      end
      #1;
      if (c < 3) chk("st_tput", inReady, 1);
      if (outValid) begin
        if (held_v) chk("st_hold", {bSel, mispredict, target}, held);
        if (outReady) begin
          if (got < 6) begin
            chk("st_tgt", target, st_tgt[got]);
            chk("st_bsel", bSel, st_bsel[got]);
          end else begin
            chk("st_extra", got, 5);
          end
          got++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held   = {bSel, mispredict, target};
        end
      end else begin
        held_v = 1'b0;
      end
      if (inValid && inReady) sent++;
    end
    inValid = 1'b0;
    chk("st_cnt", got, 6);

    // Reset in the middle of a transaction discards it.
    run_one("rm_req", 3'b000, 32'h3, 32'h3, 32'h40, 32'h10, 0, 1, 32'h50, 1, 0);
    outReady = 1'b0;
    @(negedge clk);
    bCtrl = 3'b000; r1 = 32'h3; r2 = 32'h3; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    #1 chk("rm_pre", outValid, 1);
    rstN = 1'b0;
    #1 chk("rm_ov", outValid, 0);
    chk("rm_bht", lookupTaken, 0);
    @(negedge clk);
    rstN = 1'b1; outReady = 1'b1;
    #1 chk("rm_rdy", inReady, 1);
    @(negedge clk);
    #1 chk("rm_idle", outValid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
